// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared types and constants for the seven-segment display scheduler.
// Contents: FSM state enum, index width, nibble codes of the driver decode table, default idle word.
package sevenseg_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_SHOW} state_e;
    localparam int IDX_W = 3;
    // Driver decode table: 0..3 render the letters of the idle banner, A..F render hex letters.
    typedef enum logic [3:0] {
        NIB_C  = 4'h0,
        NIB_S  = 4'h1,
        NIB_O  = 4'h2,
        NIB_C2 = 4'h3,
        NIB_A  = 4'hA,
        NIB_B  = 4'hB,
        NIB_CH = 4'hC,
        NIB_D  = 4'hD,
        NIB_E  = 4'hE,
        NIB_F  = 4'hF
    } nib_e;
    // Renders as "CSoC".
    localparam logic [15:0] IDLE_WORD_DEF = {NIB_C, NIB_S, NIB_O, NIB_C2};
endpackage

// File: rtl/sevenseg_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, search starts just after the last winner.
// Ports: req (request vector), last (previous winner index),
//        grant (one-hot winner, zero when no request), idx (winner index, 0 when none).
module rr_arbiter
    import sevenseg_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);
    logic [7:0] req8;
    logic [7:0] gnt8;
    int j;
    // Scan from the farthest candidate to the nearest so the nearest set bit is assigned last and wins.
    always_comb begin
        req8 = 8'(req);
        gnt8 = '0;
        idx  = '0;
        j    = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(last) + k) % N;
            if (req8[3'(j)]) begin
                gnt8 = 8'd1 << 3'(j);
                idx  = 3'(j);
            end
        end
        grant = gnt8[N-1:0];
    end
endmodule

// File: rtl/sevenseg_sched.sv
// sevenseg_sched: round-robin scheduler sharing a 4-digit seven-segment driver among N_REQ producers.
// Ports: clk, rst (sync, active-high); req_valid/req_data/req_dp (per-requester message offer),
//        req_ready (registered one-cycle grant pulse); skip (ends the current dwell early);
//        digit0..digit3, decplace (driver inputs); busy (high while showing); cur_src (shown requester).
module sevenseg_sched
    import sevenseg_pkg::*;
#(
    parameter int          N_REQ       = 3,
    parameter int          HOLD_CYCLES = 50000000,
    parameter int          CNT_W       = 26,
    parameter logic [15:0] IDLE_WORD   = IDLE_WORD_DEF,
    parameter logic [1:0]  IDLE_DP     = 2'b00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [16*N_REQ-1:0]  req_data,
    input  logic [2*N_REQ-1:0]   req_dp,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 skip,
    output logic [3:0]           digit0,
    output logic [3:0]           digit1,
    output logic [3:0]           digit2,
    output logic [3:0]           digit3,
    output logic [1:0]           decplace,
    output logic                 busy,
    output logic [2:0]           cur_src
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [N_REQ-1:0]   ready_q, ready_d;
    logic [15:0]        word_q, word_d;
    logic [1:0]         dp_q, dp_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   src_q, src_d;
    logic [N_REQ-1:0]   gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               valid_sel;
    logic [15:0]        data_sel;
    logic [1:0]         dp_sel;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req   (req_valid),
        .last  (last_q),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    // Message of the requester granted in the previous cycle.
    always_comb begin
        valid_sel = 1'b0;
        data_sel  = '0;
        dp_sel    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (3'(i) == win_q) begin
                valid_sel = req_valid[i];
                data_sel  = req_data[16*i +: 16];
                dp_sel    = req_dp[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        win_d   = win_q;
        ready_d = '0;
        word_d  = word_q;
        dp_d    = dp_q;
        busy_d  = busy_q;
        src_d   = src_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    ready_d = gnt;
                    win_d   = gnt_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A withdrawn offer leaves last untouched so the same search order repeats.
                if (valid_sel) begin
                    state_d = ST_SHOW;
                    word_d  = data_sel;
                    dp_d    = dp_sel;
                    last_d  = win_q;
                    src_d   = win_q;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHOW: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1) || skip) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    word_d  = IDLE_WORD;
                    dp_d    = IDLE_DP;
                    busy_d  = 1'b0;
                    src_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            win_q   <= '0;
            ready_q <= '0;
            word_q  <= IDLE_WORD;
            dp_q    <= IDLE_DP;
            busy_q  <= 1'b0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            win_q   <= win_d;
            ready_q <= ready_d;
            word_q  <= word_d;
            dp_q    <= dp_d;
            busy_q  <= busy_d;
            src_q   <= src_d;
        end
    end

    assign req_ready                        = ready_q;
    assign {digit0, digit1, digit2, digit3} = word_q;
    assign decplace                         = dp_q;
    assign busy                             = busy_q;
    assign cur_src                          = src_q;
endmodule

// File: tb/tb_sevenseg_sched.sv
// tb_sevenseg_sched: directed self-checking bench for sevenseg_sched (N_REQ=3, HOLD_CYCLES=8).
module tb_sevenseg_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [47:0] req_data = '0;
    logic [5:0]  req_dp = '0;
    logic        skip = 1'b0;
    logic [2:0]  req_ready;
    logic [3:0]  digit0, digit1, digit2, digit3;
    logic [1:0]  decplace;
    logic        busy;
    logic [2:0]  cur_src;
    logic [24:0] outs;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    sevenseg_sched #(
        .N_REQ(3), .HOLD_CYCLES(8), .CNT_W(4), .IDLE_WORD(16'h0123), .IDLE_DP(2'b00)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_dp(req_dp),
        .req_ready(req_ready), .skip(skip), .digit0(digit0), .digit1(digit1), .digit2(digit2),
        .digit3(digit3), .decplace(decplace), .busy(busy), .cur_src(cur_src)
    );

    always #5 clk = ~clk;

    assign outs = {req_ready, digit0, digit1, digit2, digit3, decplace, busy, cur_src};

    typedef struct {
        logic        r;
        logic [2:0]  v;
        logic [15:0] d;
        logic [1:0]  dp;
        logic        sk;
        logic [31:0] e;
        string       nm;
    } vec_t;

    function automatic logic [31:0] ex(logic [2:0] r, logic [15:0] w, logic [1:0] d, logic b, logic [2:0] s);
        return {7'd0, r, w, d, b, s};
    endfunction

    function automatic vec_t mk(logic r, logic [2:0] v, logic [15:0] d, logic [1:0] dp, logic sk,
                                logic [31:0] e, string nm);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.dp = dp; t.sk = sk; t.e = e; t.nm = nm;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    vec_t        tv[19];
    logic [15:0] wd[3];
    logic [1:0]  wp[3];
    logic [31:0] idle_o;

    initial begin
        int prev;
        int w;
        idle_o = ex(3'b000, 16'h0123, 2'b00, 1'b0, 3'd0);
        wd = '{16'hA001, 16'hB002, 16'hC003};
        wp = '{2'b01, 2'b10, 2'b11};
        tv[0] = mk(1, 3'b000, 16'h0000, 2'b00, 0, idle_o, "t2_reset");
        tv[1] = mk(0, 3'b001, 16'h7E57, 2'b10, 0, ex(3'b001, 16'h0123, 2'b00, 0, 0), "t2_grant");
        tv[2] = mk(0, 3'b001, 16'h7E57, 2'b10, 0, ex(3'b000, 16'h7E57, 2'b10, 1, 0), "t2_show0");
        for (int i = 3; i <= 9; i++)
            tv[i] = mk(0, 3'b000, 16'h1111, 2'b01, 0, ex(3'b000, 16'h7E57, 2'b10, 1, 0), "t2_hold");
        tv[10] = mk(0, 3'b000, 16'h1111, 2'b01, 0, idle_o, "t2_end");
        tv[11] = mk(0, 3'b000, 16'h1111, 2'b01, 0, idle_o, "t2_idle");
        tv[12] = mk(1, 3'b000, 16'h0000, 2'b00, 0, idle_o, "t4_reset");
        tv[13] = mk(0, 3'b010, 16'h5555, 2'b11, 0, ex(3'b010, 16'h0123, 2'b00, 0, 0), "t4_grant");
        tv[14] = mk(0, 3'b000, 16'h5555, 2'b11, 0, idle_o, "t4_withdraw");
        tv[15] = mk(0, 3'b000, 16'h5555, 2'b11, 1, idle_o, "t4_idle_skip");
        tv[16] = mk(0, 3'b110, 16'h5555, 2'b11, 0, ex(3'b010, 16'h0123, 2'b00, 0, 0), "t4_search_from0");
        tv[17] = mk(0, 3'b000, 16'h5555, 2'b11, 0, idle_o, "t4_withdraw2");
        tv[18] = mk(0, 3'b000, 16'h5555, 2'b11, 0, idle_o, "t4_idle");

        // Test 1: reset and long idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("t1_reset", 32'(outs), idle_o);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("t1_idle", 32'(outs), idle_o);
        end

        // Tests 2 and 4: table-driven
        foreach (tv[i]) begin
            rst = tv[i].r;
            req_valid = tv[i].v;
            req_data = {32'h0, tv[i].d};
            req_dp = {4'h0, tv[i].dp};
            skip = tv[i].sk;
            tick();
            chk(tv[i].nm, 32'(outs), tv[i].e);
        end
        rst = 1'b0;
        skip = 1'b0;

        // Test 3: all requesters continuously valid
        req_data = {wd[2], wd[1], wd[0]};
        req_dp = {wp[2], wp[1], wp[0]};
        req_valid = 3'b111;
        prev = 0;
        for (int g = 0; g < 6; g++) begin
            w = 0;
            tick();
            while (req_ready == 3'b000 && w < 20) begin
                tick();
                w++;
            end
            chk("t3_grant", 32'(outs), ex(3'b001 << (g % 3), 16'h0123, 2'b00, 0, 0));
            if (g > 0) chk("t3_spacing", 32'(cyc - prev), 32'd10);
            prev = cyc;
            tick();
            chk("t3_show", 32'(outs), ex(3'b000, wd[g % 3], wp[g % 3], 1, 3'(g % 3)));
        end
        req_valid = 3'b000;
        w = 0;
        while (busy && w < 20) begin
            tick();
            w++;
        end
        chk("t3_back_idle", 32'(outs), idle_o);

        // Test 5: skip mid-dwell, skip ignored in GRANT, skip at terminal count
        req_valid = 3'b011;
        tick();
        chk("t5_grant0", 32'(outs), ex(3'b001, 16'h0123, 2'b00, 0, 0));
        tick();
        tick();
        tick();
        tick();
        chk("t5_cnt3", 32'(outs), ex(3'b000, wd[0], wp[0], 1, 0));
        skip = 1'b1;
        tick();
        skip = 1'b0;
        chk("t5_skip_idle", 32'(outs), idle_o);
        skip = 1'b1;
        tick();
        chk("t5_grant1", 32'(outs), ex(3'b010, 16'h0123, 2'b00, 0, 0));
        tick();
        skip = 1'b0;
        req_valid = 3'b000;
        chk("t5_skip_in_grant", 32'(outs), ex(3'b000, wd[1], wp[1], 1, 1));
        for (int i = 0; i < 7; i++) tick();
        chk("t5_cnt7", 32'(outs), ex(3'b000, wd[1], wp[1], 1, 1));
        skip = 1'b1;
        tick();
        skip = 1'b0;
        chk("t5_tc_skip", 32'(outs), idle_o);
        tick();
        chk("t5_single", 32'(outs), idle_o);

        // Test 6: reset during SHOW and during the GRANT pulse
        req_valid = 3'b001;
        tick();
        chk("t6_grant0", 32'(outs), ex(3'b001, 16'h0123, 2'b00, 0, 0));
        tick();
        tick();
        chk("t6_show", 32'(outs), ex(3'b000, wd[0], wp[0], 1, 0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_show", 32'(outs), idle_o);
        req_valid = 3'b101;
        tick();
        chk("t6_from0", 32'(outs), ex(3'b001, 16'h0123, 2'b00, 0, 0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_grant", 32'(outs), idle_o);
        req_valid = 3'b110;
        tick();
        chk("t6_after_rst", 32'(outs), ex(3'b010, 16'h0123, 2'b00, 0, 0));
        req_valid = 3'b000;
        tick();
        chk("t6_withdraw", 32'(outs), idle_o);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sevenseg_sched.md
Name: sevenseg_sched

Overview:
Round-robin scheduler that shares the 4-digit seven-segment display driver between N_REQ message producers. Each producer offers a 16-bit nibble word plus a decimal-point position over a valid/ready handshake. The scheduler latches one message, holds it on the display for a programmable dwell time, then arbitrates again. When no producer is pending, it shows a fixed idle word (IDLE_WORD default 16'h0123, which the downstream driver renders as "CSoC"). Its outputs drive the driver's digit0..digit3 and decplace inputs directly.

Parameters:
N_REQ, 3, number of requesters (1..8).
HOLD_CYCLES, 50000000, dwell time per message in clk cycles (1 s at 50 MHz); must be >= 2.
CNT_W, 26, dwell counter width; must satisfy 2**CNT_W > HOLD_CYCLES.
IDLE_WORD, 16'h0123, nibble word shown when idle; bits [15:12] map to digit0 (leftmost).
IDLE_DP, 2'b00, decplace value shown when idle.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req_valid  input  N_REQ  requester i has a message pending
req_data  input  16*N_REQ  message word; requester i uses bits [16*i+15:16*i]
req_dp  input  2*N_REQ  decimal-point position; requester i uses bits [2*i+1:2*i]
req_ready  output  N_REQ  one-hot grant pulse; message is accepted when valid&ready
skip  input  1  single-cycle pulse that ends the current dwell early
digit0  output  4  leftmost nibble, equal to word[15:12]
digit1  output  4  word[11:8]
digit2  output  4  word[7:4]
digit3  output  4  rightmost nibble, equal to word[3:0]
decplace  output  2  decimal-point position passed to the driver
busy  output  1  high while in SHOW
cur_src  output  3  index of the requester currently shown; 0 when idle

Behaviour:
- Registered outputs only. req_ready is registered as a one-cycle pulse.
- On reset:
  - state goes to IDLE; dwell counter = 0; round-robin pointer last = N_REQ-1.
  - digits = IDLE_WORD; decplace = IDLE_DP; busy = 0; cur_src = 0; req_ready = 0.
- The FSM has states IDLE, GRANT, SHOW.
- IDLE:
  - Each cycle, search req_valid starting at index (last+1) mod N_REQ and wrapping; the first set bit wins.
  - If a winner exists: assert req_ready[winner] for exactly one cycle (the following cycle) and move to GRANT.
  - If none exists: keep showing IDLE_WORD/IDLE_DP.
- GRANT (one cycle, req_ready[winner] high):
  - If req_valid[winner] is still 1: latch req_data/req_dp into the output registers, so the display changes on the next cycle. Also set last = winner, cur_src = winner, busy = 1, counter = 0, and go to SHOW.
  - If the requester withdrew valid: no transfer; go back to IDLE with last unchanged.
- SHOW:
  - The counter increments each cycle. When counter == HOLD_CYCLES-1, or skip == 1, go to IDLE.
  - On that transition busy falls and the outputs revert to IDLE_WORD/IDLE_DP, unless a new grant completes.
  - Grant-to-grant minimum period is HOLD_CYCLES + 2 cycles.
- A producer must hold data stable while valid is high. Data is sampled only in the GRANT cycle, and later changes do not affect the current display.
- Fairness: a requester that holds valid continuously is served within N_REQ dwell periods. The just-served requester has the lowest priority in the next search.
- skip is ignored in IDLE and GRANT. A skip that coincides with terminal count gives a single transition.
- rst in any state, including mid-SHOW or during the GRANT pulse, takes priority. Outputs return to reset values on the next edge, no transfer is counted, and req_ready goes low.
- N_REQ == 1: the pointer logic degenerates and the single requester is re-granted after each dwell while its valid is high.

Decomposition:
- A shared package sevenseg_pkg holds:
  - the FSM state enum (IDLE, GRANT, SHOW);
  - default IDLE_WORD;
  - symbolic nibble codes used by the driver's decode table (C=0, S=1, o=2, ... A..F).
- Sub-module rr_arbiter: parameter N; inputs req and last; outputs a one-hot grant and an index. It is purely combinational, and the scheduler instantiates it once.

Test Plan:
1. Reset, no requests, HOLD_CYCLES=8 -> digits 0,1,2,3; decplace 00; busy 0; req_ready stays 0 for 100 cycles.
2. req_valid=001, req_data[15:0]=16'h7E57, dp=2'b10 -> req_ready[0] pulses 1 cycle. Next cycle digits 7,E,5,7, decplace 10, busy 1 for exactly 8 cycles, then the idle word returns.
3. All three requesters hold valid continuously -> grants go in order 0,1,2,0,1,2, with grant-to-grant spacing of 10 cycles (HOLD_CYCLES+2). cur_src tracks each grant.
4. req_valid[1] asserted, then dropped during the GRANT cycle -> no display change, busy stays 0, and the next search still starts at index 0.
5. In SHOW with counter = 3, pulse skip -> busy falls next cycle and a pending requester is granted. Also test skip coinciding with terminal count -> exactly one transition.
6. rst asserted during SHOW and during the GRANT pulse -> next cycle outputs equal the reset values, req_ready = 0, and the next arbitration starts from index 0.
